// File: rtl/dht11_ctrl.sv
// DHT11 single-wire sensor controller: host start pulse, 40-bit frame capture,
// checksum verification and one-cycle done/err reporting of RH and T bytes.
module dht11_ctrl #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  inout  wire        dht_io,
  output logic [7:0] rh_data,
  output logic [7:0] t_data,
  output logic       dht11_done,
  output logic       dht11_err,
  output logic       busy
);

  // state     | meaning
  // IDLE      | line released, waiting for start
  // START_LOW | host holds line low for START_LOW_US
  // WAIT_ACK  | line released, waiting for sensor to pull low
  // RESP_LOW  | sensor response low phase
  // RESP_HIGH | sensor response high phase
  // BIT_LOW   | low preamble of a data bit
  // BIT_HIGH  | high phase of a data bit, length encodes the value
  // CHECK     | one cycle checksum verification
  typedef enum logic [2:0] {
    IDLE, START_LOW, WAIT_ACK, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  localparam int DIV    = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int DW     = $clog2(DIV + 1);
  localparam int MAX_US = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int CW     = $clog2(MAX_US + 2);

  state_t          state, state_next;
  logic [DW-1:0]   tick_cnt;
  logic            tick;
  logic [CW-1:0]   us_cnt;
  logic            sync1, sync2, prev;
  logic            rise, fall;
  logic [39:0]     shreg;
  logic [5:0]      bit_cnt;
  logic            shift_en, load, err_set, waiting, timeout, bit_val;
  logic [7:0]      sum;

  assign tick    = (tick_cnt == '0);
  assign rise    = sync2 & ~prev;
  assign fall    = ~sync2 & prev;
  assign timeout = (us_cnt >= CW'(TIMEOUT_US));
  assign bit_val = (us_cnt >= CW'(BIT_THRESH_US));
  assign waiting = (state == WAIT_ACK) || (state == RESP_LOW) || (state == RESP_HIGH) ||
                   (state == BIT_LOW)  || (state == BIT_HIGH);

  // Open-drain: the host only ever pulls low; the pull-up supplies the 1.
  assign dht_io = (state == START_LOW) ? 1'b0 : 1'bz;

  // The pulse cycle still counts as busy so start is taken only once outputs settle.
  assign busy = (state != IDLE) | dht11_done | dht11_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    load       = 1'b0;
    err_set    = 1'b0;
    sum        = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
    case (state)
      IDLE:      if (start && !busy) state_next = START_LOW;
      START_LOW: if (tick && us_cnt == CW'(START_LOW_US - 1)) state_next = WAIT_ACK;
      WAIT_ACK:  if (fall) state_next = RESP_LOW;
      RESP_LOW:  if (rise) state_next = RESP_HIGH;
      RESP_HIGH: if (fall) state_next = BIT_LOW;
      BIT_LOW:   if (rise) state_next = BIT_HIGH;
      BIT_HIGH:  if (fall) begin
                   shift_en   = 1'b1;
                   state_next = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
                 end
      CHECK: begin
        state_next = IDLE;
        if (sum == shreg[7:0]) load = 1'b1;
        else                   err_set = 1'b1;
      end
      default:   state_next = IDLE;
    endcase
    if (waiting && timeout && state_next == state) begin
      state_next = IDLE;
      err_set    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      tick_cnt <= '0;
      us_cnt   <= '0;
    end else begin
      sync1 <= dht_io;
      sync2 <= sync1;
      prev  <= sync2;
      if (tick) tick_cnt <= DW'(DIV - 1);
      else      tick_cnt <= tick_cnt - DW'(1);
      if (state_next != state)          us_cnt <= '0;
      else if (tick && state != IDLE)   us_cnt <= us_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      rh_data    <= '0;
      t_data     <= '0;
      dht11_done <= 1'b0;
      dht11_err  <= 1'b0;
    end else begin
      dht11_done <= load;
      dht11_err  <= err_set;
      if (state == IDLE && state_next == START_LOW) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= {shreg[38:0], bit_val};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (load) begin
        rh_data <= shreg[39:32];
        t_data  <= shreg[23:16];
      end
    end
  end

endmodule

// File: tb/tb_dht11_ctrl.sv
// Bench for dht11_ctrl: open-drain sensor model with pull-up, randomized frames
// and bit timings, checked against a frame-level decode/checksum model.
module tb_dht11_ctrl;
  localparam int CLK_HZ = 2_000_000;
  localparam int CPU    = CLK_HZ / 1_000_000;
  localparam int SLU    = 60;
  localparam int THR    = 40;
  localparam int TOU    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       drv_low = 1'b0;
  wire        dht_io;
  logic [7:0] rh_data, t_data;
  logic       dht11_done, dht11_err, busy;

  assign dht_io = drv_low ? 1'b0 : 1'bz;
  pullup (dht_io);

  always #5 clk = ~clk;

  dht11_ctrl #(.CLK_HZ(CLK_HZ), .START_LOW_US(SLU), .BIT_THRESH_US(THR), .TIMEOUT_US(TOU)) dut (
    .clk(clk), .rst(rst), .start(start), .dht_io(dht_io),
    .rh_data(rh_data), .t_data(t_data),
    .dht11_done(dht11_done), .dht11_err(dht11_err), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Pulse monitor
  int   n_done = 0, n_err = 0;
  logic [7:0] cap_rh, cap_t;
  logic at_busy, after_busy, chk_after = 1'b0, prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (chk_after) begin
      after_busy = busy;
      chk_after  = 1'b0;
    end
    if (dht11_done || dht11_err) begin
      chk("pulse_exclusive", int'(dht11_done & dht11_err), 0);
      chk("pulse_width", int'(prev_pulse), 0);
      at_busy   = busy;
      chk_after = 1'b1;
    end
    if (dht11_done) begin
      n_done++;
      cap_rh = rh_data;
      cap_t  = t_data;
    end
    if (dht11_err) n_err++;
    prev_pulse = dht11_done | dht11_err;
  end

  logic [7:0] fb [5];
  int         hi_us [40];
  logic [7:0] exp_rh = 8'h00, exp_t = 8'h00;

  task automatic wait_us(input int us);
    repeat (us * CPU) @(negedge clk);
  endtask

  // Issue start and measure the host low pulse; returns with the line just released.
  task automatic host_start(output int len);
    int w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (dht_io !== 1'b0 && w < 10) begin @(negedge clk); w++; end
    chk("start_drive", int'(dht_io), 0);
    len = 0;
    while (dht_io === 1'b0 && len < SLU * CPU + 20) begin len++; @(negedge clk); end
    chk("start_ticks", (len + 1) / CPU, SLU);
  endtask

  // mode 0: nominal 27/70 us, 1: mix of nominal and 39/41 us, 2: random outside 40 us.
  task automatic run_frame(input int mode, input int start_bit, input int abort_bit);
    logic [7:0] d [5];
    logic [7:0] s;
    int nd0, ne0, len, ed, ee;
    bit one;
    for (int i = 0; i < 40; i++) begin
      one = fb[i / 8][7 - (i % 8)];
      case (mode)
        0:       hi_us[i] = one ? 70 : 27;
        1:       hi_us[i] = (i % 2) ? (one ? 41 : 39) : (one ? 70 : 27);
        default: hi_us[i] = one ? int'($urandom_range(75, 41)) : int'($urandom_range(39, 20));
      endcase
    end
    for (int i = 0; i < 5; i++) d[i] = 8'h00;
    for (int i = 0; i < 40; i++) d[i / 8] = {d[i / 8][6:0], (hi_us[i] >= THR)};
    s  = d[0] + d[1] + d[2] + d[3];
    ed = (s == d[4]) ? 1 : 0;
    ee = 1 - ed;
    nd0 = n_done;
    ne0 = n_err;
    host_start(len);
    wait_us(20);
    drv_low = 1'b1; wait_us(40);
    drv_low = 1'b0; wait_us(40);
    for (int i = 0; i < 40; i++) begin
      if (i == abort_bit) begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_line", int'(dht_io), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rh", int'(rh_data), 0);
        chk("rst_t", int'(t_data), 0);
        chk("rst_done", int'(dht11_done), 0);
        chk("rst_err", int'(dht11_err), 0);
        exp_rh = 8'h00;
        exp_t  = 8'h00;
        rst = 1'b1;
        wait_us(300);
        chk("rst_no_pulse", (n_done - nd0) + (n_err - ne0), 0);
        return;
      end
      drv_low = 1'b1;
      if (i == start_bit) begin
        chk("busy_mid", int'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25 * CPU - 1) @(negedge clk);
      end else begin
        wait_us(25);
      end
      drv_low = 1'b0;
      wait_us(hi_us[i]);
    end
    drv_low = 1'b1; wait_us(25);
    drv_low = 1'b0; wait_us(10);
    if (ed == 1) begin
      exp_rh = d[0];
      exp_t  = d[2];
    end
    chk("done_cnt", n_done - nd0, ed);
    chk("err_cnt", n_err - ne0, ee);
    chk("rh_data", int'(rh_data), int'(exp_rh));
    chk("t_data", int'(t_data), int'(exp_t));
    chk("busy_at_pulse", int'(at_busy), 1);
    chk("busy_after_pulse", int'(after_busy), 0);
    if (ed == 1) begin
      chk("cap_rh", int'(cap_rh), int'(exp_rh));
      chk("cap_t", int'(cap_t), int'(exp_t));
    end
  endtask

  task automatic set_frame(input logic [7:0] b0, b1, b2, b3, b4);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
  endtask

  initial begin
    int len, cnt, ne0;
    logic [7:0] r [4];
    repeat (4) @(negedge clk);
    chk("reset_rh", int'(rh_data), 0);
    chk("reset_t", int'(t_data), 0);
    chk("reset_done", int'(dht11_done), 0);
    chk("reset_err", int'(dht11_err), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_line", int'(dht_io), 1);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    set_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h50);
    run_frame(0, -1, -1);

    set_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h51);
    run_frame(0, -1, -1);

    // No sensor: line stays high, WAIT_ACK must time out
    ne0 = n_err;
    host_start(len);
    cnt = 0;
    while (!dht11_err && cnt < TOU * CPU + 50) begin @(negedge clk); cnt++; end
    chk("timeout_us", cnt / CPU, TOU);
    @(negedge clk);
    chk("timeout_err_cnt", n_err - ne0, 1);
    chk("timeout_idle", int'(busy), 0);
    chk("timeout_rh", int'(rh_data), int'(exp_rh));
    chk("timeout_t", int'(t_data), int'(exp_t));

    set_frame(8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'hFE);
    run_frame(1, -1, -1);

    set_frame(8'h2A, 8'h01, 8'h17, 8'h05, 8'h47);
    run_frame(0, 10, -1);

    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) r[j] = 8'($urandom);
      set_frame(r[0], r[1], r[2], r[3],
                8'(r[0] + r[1] + r[2] + r[3] + (($urandom % 4 == 0) ? 8'($urandom_range(255, 1)) : 8'h00)));
      run_frame(2, -1, -1);
    end

    set_frame(8'h40, 8'h00, 8'h1C, 8'h00, 8'h5C);
    run_frame(0, -1, 20);

    set_frame(8'h37, 8'h00, 8'h19, 8'h00, 8'h50);
    run_frame(0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
